// File: rtl/lsu_sq.sv
`default_nettype none
// ============================================================================
// Module      : lsu_sq
// Description : LSU store queue. Holds issued stores in program order,
//               writes the head store to the data cache once the ROB retires
//               it, then broadcasts the retired store's address and width to
//               the load queue for mis-speculation detection.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_sq #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int SQ_DEPTH     = 8,
    parameter int SQ_TAG_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    output logic                  o_full,
    input  logic                  i_alloc_en,
    input  logic [TAG_WIDTH-1:0]  i_alloc_tag,
    input  logic [ADDR_WIDTH-1:0] i_alloc_addr,
    input  logic [DATA_WIDTH-1:0] i_alloc_data,
    input  logic [3:0]            i_alloc_width,
    input  logic                  i_retire_en,
    input  logic [TAG_WIDTH-1:0]  i_retire_tag,
    output logic                  o_retire_ack,
    output logic                  o_dc_wr_en,
    output logic [ADDR_WIDTH-1:0] o_dc_addr,
    output logic [DATA_WIDTH-1:0] o_dc_data,
    output logic [3:0]            o_dc_width,
    input  logic                  i_dc_ack,
    output logic                  o_sq_retire_en,
    output logic [ADDR_WIDTH-1:0] o_sq_retire_addr,
    output logic [3:0]            o_sq_retire_width
);

    localparam int PTR_W = SQ_TAG_WIDTH;
    localparam int CNT_W = SQ_TAG_WIDTH + 1;

    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] c_CNT_FULL  = CNT_W'(SQ_DEPTH);

    // Commit FSM encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_ACK   = 2'd2;

    // Entry payload storage (intentionally not reset)
    logic [TAG_WIDTH-1:0]  mem_tag_q   [SQ_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_q  [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q  [SQ_DEPTH];
    logic [3:0]            mem_width_q [SQ_DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;

    logic [ADDR_WIDTH-1:0] dc_addr_q, dc_addr_d;
    logic [DATA_WIDTH-1:0] dc_data_q, dc_data_d;
    logic [3:0]            dc_width_q, dc_width_d;
    logic [ADDR_WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic [3:0]            ret_width_q, ret_width_d;

    logic w_full;
    logic w_alloc_ok;
    logic w_pop;
    logic w_retire_hit;

    // Queue status and qualified alloc/pop events
    always_comb begin
        w_full       = (count_q == c_CNT_FULL);
        // Flush wins over a same-cycle alloc; full is judged before any pop.
        w_alloc_ok   = i_alloc_en && !w_full && !i_flush;
        w_pop        = (state_q == c_ST_ACK);
        w_retire_hit = i_retire_en && (count_q != c_CNT_ZERO) &&
                       (mem_tag_q[head_q] == i_retire_tag);
    end

    // Entry payload write at the tail on an accepted allocation
    always_ff @(posedge clk) begin
        if (w_alloc_ok) begin
            mem_tag_q[tail_q]   <= i_alloc_tag;
            mem_addr_q[tail_q]  <= i_alloc_addr;
            mem_data_q[tail_q]  <= i_alloc_data;
            mem_width_q[tail_q] <= i_alloc_width;
        end
    end

    // Head/tail/count update including flush handling
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_pop) begin
            head_d = head_q + c_PTR_ONE;
        end
        if (i_flush) begin
            if (state_q == c_ST_IDLE) begin
                tail_d  = head_q;
                count_d = c_CNT_ZERO;
            end else begin
                // The committing head store is older than the flush and survives;
                // if it pops this cycle the queue ends up empty.
                tail_d  = head_q + c_PTR_ONE;
                count_d = w_pop ? c_CNT_ZERO : c_CNT_ONE;
            end
        end else begin
            if (w_alloc_ok) begin
                tail_d = tail_q + c_PTR_ONE;
            end
            if (w_alloc_ok && !w_pop) begin
                count_d = count_q + c_CNT_ONE;
            end else if (!w_alloc_ok && w_pop) begin
                count_d = count_q - c_CNT_ONE;
            end
        end
    end

    // Commit FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (w_retire_hit) state_d = c_ST_WRITE;
            c_ST_WRITE: if (i_dc_ack)     state_d = c_ST_ACK;
            c_ST_ACK:                     state_d = c_ST_IDLE;
            default:                      state_d = c_ST_IDLE;
        endcase
    end

    // Commit FSM outputs
    always_comb begin
        o_dc_wr_en     = (state_q == c_ST_WRITE);
        o_retire_ack   = (state_q == c_ST_ACK);
        o_sq_retire_en = (state_q == c_ST_ACK);
    end

    // Registered D$ request payload and LQ broadcast payload
    always_comb begin
        dc_addr_d   = dc_addr_q;
        dc_data_d   = dc_data_q;
        dc_width_d  = dc_width_q;
        ret_addr_d  = '0;
        ret_width_d = '0;
        if ((state_q == c_ST_IDLE) && w_retire_hit) begin
            dc_addr_d  = mem_addr_q[head_q];
            dc_data_d  = mem_data_q[head_q];
            dc_width_d = mem_width_q[head_q];
        end
        // The head does not move during WRITE, so the captured request is the head.
        if ((state_q == c_ST_WRITE) && i_dc_ack) begin
            ret_addr_d  = dc_addr_q;
            ret_width_d = dc_width_q;
        end
    end

    // Pointer, counter and payload register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            dc_addr_q   <= '0;
            dc_data_q   <= '0;
            dc_width_q  <= '0;
            ret_addr_q  <= '0;
            ret_width_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            dc_addr_q   <= dc_addr_d;
            dc_data_q   <= dc_data_d;
            dc_width_q  <= dc_width_d;
            ret_addr_q  <= ret_addr_d;
            ret_width_q <= ret_width_d;
        end
    end

    // Output wiring
    always_comb begin
        o_full            = w_full;
        o_dc_addr         = dc_addr_q;
        o_dc_data         = dc_data_q;
        o_dc_width        = dc_width_q;
        o_sq_retire_addr  = ret_addr_q;
        o_sq_retire_width = ret_width_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_sq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_sq
// Description : Directed self-checking bench for the lsu_sq store queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_sq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic        o_full;
    logic        i_alloc_en;
    logic [5:0]  i_alloc_tag;
    logic [31:0] i_alloc_addr;
    logic [31:0] i_alloc_data;
    logic [3:0]  i_alloc_width;
    logic        i_retire_en;
    logic [5:0]  i_retire_tag;
    logic        o_retire_ack;
    logic        o_dc_wr_en;
    logic [31:0] o_dc_addr;
    logic [31:0] o_dc_data;
    logic [3:0]  o_dc_width;
    logic        i_dc_ack;
    logic        o_sq_retire_en;
    logic [31:0] o_sq_retire_addr;
    logic [3:0]  o_sq_retire_width;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_sq dut (
        .clk               (clk),
        .rst               (rst),
        .i_flush           (i_flush),
        .o_full            (o_full),
        .i_alloc_en        (i_alloc_en),
        .i_alloc_tag       (i_alloc_tag),
        .i_alloc_addr      (i_alloc_addr),
        .i_alloc_data      (i_alloc_data),
        .i_alloc_width     (i_alloc_width),
        .i_retire_en       (i_retire_en),
        .i_retire_tag      (i_retire_tag),
        .o_retire_ack      (o_retire_ack),
        .o_dc_wr_en        (o_dc_wr_en),
        .o_dc_addr         (o_dc_addr),
        .o_dc_data         (o_dc_data),
        .o_dc_width        (o_dc_width),
        .i_dc_ack          (i_dc_ack),
        .o_sq_retire_en    (o_sq_retire_en),
        .o_sq_retire_addr  (o_sq_retire_addr),
        .o_sq_retire_width (o_sq_retire_width)
    );

    // Store payload derived from the tag
    function automatic logic [31:0] f_addr(input logic [5:0] tag);
        return 32'h100 + 32'(tag - 6'd1) * 32'h10;
    endfunction

    function automatic logic [31:0] f_data(input logic [5:0] tag);
        return (tag == 6'd1) ? 32'hDEADBEEF : {26'h2A5A5A5, tag};
    endfunction

    function automatic logic [3:0] f_width(input logic [5:0] tag);
        if (tag == 6'd1)          return 4'd4;
        else if (tag % 3 == 0)    return 4'd1;
        else if (tag % 3 == 1)    return 4'd2;
        else                      return 4'd4;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alloc(input logic [5:0] tag);
        i_alloc_en    = 1'b1;
        i_alloc_tag   = tag;
        i_alloc_addr  = f_addr(tag);
        i_alloc_data  = f_data(tag);
        i_alloc_width = f_width(tag);
    endtask

    task automatic alloc(input logic [5:0] tag);
        drive_alloc(tag);
        step();
        i_alloc_en = 1'b0;
    endtask

    // Full retire handshake: accept, WRITE for 'delay' cycles (ack in the last),
    // then the ACK pulse. Optionally flush in the first WRITE cycle and/or
    // present an allocation during the ACK cycle.
    task automatic retire(input logic [5:0] tag, input int delay,
                          input bit flush_in_write, input bit alloc_in_ack,
                          input logic [5:0] atag);
        i_retire_en  = 1'b1;
        i_retire_tag = tag;
        step();
        for (int i = 0; i < delay; i++) begin
            chk($sformatf("dc_wr_en t%0d c%0d", tag, i), 64'(o_dc_wr_en), 64'd1);
            if (i == 0) begin
                chk($sformatf("dc_addr t%0d", tag),  64'(o_dc_addr),  64'(f_addr(tag)));
                chk($sformatf("dc_data t%0d", tag),  64'(o_dc_data),  64'(f_data(tag)));
                chk($sformatf("dc_width t%0d", tag), 64'(o_dc_width), 64'(f_width(tag)));
            end
            i_flush  = flush_in_write && (i == 0);
            i_dc_ack = (i == delay - 1);
            step();
            i_flush = 1'b0;
        end
        i_dc_ack = 1'b0;
        chk($sformatf("retire_ack t%0d", tag), 64'(o_retire_ack), 64'd1);
        chk($sformatf("sq_ret_en t%0d", tag), 64'(o_sq_retire_en), 64'd1);
        chk($sformatf("sq_ret_addr t%0d", tag), 64'(o_sq_retire_addr), 64'(f_addr(tag)));
        chk($sformatf("sq_ret_width t%0d", tag), 64'(o_sq_retire_width), 64'(f_width(tag)));
        chk($sformatf("wr_en_in_ack t%0d", tag), 64'(o_dc_wr_en), 64'd0);
        if (alloc_in_ack) drive_alloc(atag);
        step();
        i_retire_en = 1'b0;
        i_alloc_en  = 1'b0;
        chk($sformatf("ack_drop t%0d", tag), 64'(o_retire_ack), 64'd0);
    endtask

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_alloc_en = 1'b0; i_alloc_tag = '0;
        i_alloc_addr = '0; i_alloc_data = '0; i_alloc_width = '0;
        i_retire_en = 1'b0; i_retire_tag = '0; i_dc_ack = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst full",        64'(o_full),            64'd0);
        chk("rst retire_ack",  64'(o_retire_ack),      64'd0);
        chk("rst dc_wr_en",    64'(o_dc_wr_en),        64'd0);
        chk("rst sq_ret_en",   64'(o_sq_retire_en),    64'd0);
        chk("rst dc_addr",     64'(o_dc_addr),         64'd0);
        chk("rst dc_data",     64'(o_dc_data),         64'd0);
        chk("rst sq_ret_addr", 64'(o_sq_retire_addr),  64'd0);
        chk("rst count",       64'(dut.count_q),       64'd0);

        // Fill to capacity; 9th alloc is ignored
        for (int t = 1; t <= 8; t++) begin
            chk($sformatf("not full before t%0d", t), 64'(o_full), 64'd0);
            alloc(6'(t));
        end
        chk("full at 8", 64'(o_full), 64'd1);
        alloc(6'd63);
        chk("full after ignored alloc", 64'(o_full), 64'd1);
        chk("count after ignored alloc", 64'(dut.count_q), 64'd8);

        // Retire tag 1 with D$ ack on the third WRITE cycle
        retire(6'd1, 3, 1'b0, 1'b0, 6'd0);
        chk("count after t1", 64'(dut.count_q), 64'd7);
        chk("not full after t1", 64'(o_full), 64'd0);

        // Wraparound: refill, retire, allocate past index 7
        alloc(6'd9);
        chk("full with t9", 64'(o_full), 64'd1);
        for (int t = 2; t <= 4; t++) retire(6'(t), 1, 1'b0, 1'b0, 6'd0);
        for (int t = 10; t <= 12; t++) alloc(6'(t));
        chk("full after wrap alloc", 64'(o_full), 64'd1);
        for (int t = 5; t <= 9; t++) retire(6'(t), 1, 1'b0, 1'b0, 6'd0);
        chk("count after wrap retires", 64'(dut.count_q), 64'd3);
        alloc(6'd13);
        alloc(6'd14);
        chk("count 5 before flush", 64'(dut.count_q), 64'd5);

        // Flush during WRITE: head store still commits, rest discarded
        retire(6'd10, 2, 1'b1, 1'b0, 6'd0);
        chk("count after flush", 64'(dut.count_q), 64'd0);
        chk("not full after flush", 64'(o_full), 64'd0);
        alloc(6'd20);
        chk("count after post-flush alloc", 64'(dut.count_q), 64'd1);
        retire(6'd20, 1, 1'b0, 1'b0, 6'd0);

        // Alloc and pop in the same cycle while full: alloc is dropped
        for (int t = 30; t <= 37; t++) alloc(6'(t));
        chk("full with 30..37", 64'(o_full), 64'd1);
        retire(6'd30, 1, 1'b0, 1'b1, 6'd38);
        chk("count full alloc+pop", 64'(dut.count_q), 64'd7);
        chk("not full after full alloc+pop", 64'(o_full), 64'd0);
        alloc(6'd38);
        for (int t = 31; t <= 34; t++) retire(6'(t), 1, 1'b0, 1'b0, 6'd0);
        chk("count 4", 64'(dut.count_q), 64'd4);

        // Alloc and pop in the same cycle with count 4: count unchanged
        retire(6'd35, 1, 1'b0, 1'b1, 6'd39);
        chk("count alloc+pop at 4", 64'(dut.count_q), 64'd4);

        // Reset during WRITE: request dropped, no ack ever issued
        i_retire_en  = 1'b1;
        i_retire_tag = 6'd36;
        step();
        chk("t36 in WRITE", 64'(o_dc_wr_en), 64'd1);
        rst = 1'b1;
        i_retire_en = 1'b0;
        step();
        rst = 1'b0;
        chk("rst mid-write wr_en", 64'(o_dc_wr_en), 64'd0);
        chk("rst mid-write count", 64'(dut.count_q), 64'd0);
        chk("rst mid-write full",  64'(o_full), 64'd0);
        i_dc_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            i_dc_ack = 1'b0;
            chk($sformatf("no ack after rst c%0d", i), 64'(o_retire_ack), 64'd0);
            chk($sformatf("no wr_en after rst c%0d", i), 64'(o_dc_wr_en), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
